// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and the IF/ID entry type
//
// Purpose: defaults shared by the IF/ID queue and its neighbours.
// Contents:
//   PIPE_XLEN      - default pc / instruction width
//   PIPE_NOP_INSTR - addi x0,x0,0, presented to ID when nothing is queued
//   if_id_entry_t  - packed {pc, instr} pair as stored in the queue
package pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - DEPTH x WIDTH register array, one write port, one async read port
//
// Purpose: storage for the IF/ID queue. Not reset; the owner never exposes
// an entry that has not been written.
// Ports:
//   clk   - clock, write on posedge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module fifo_regfile #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - DEPTH-entry IF/ID decoupling queue with stall, flush and NOP fill
//
// Purpose: queues {pc, instr} pairs from fetch and presents the head to
// decode; presents NOP_INSTR / pc 0 while empty.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   in_valid  - IF offers an entry
//   in_pc     - pc of offered entry
//   in_instr  - offered instruction
//   in_ready  - queue not full (ignores a same-cycle pop)
//   stall     - ID holds the head
//   flush     - drop everything queued and the entry offered this cycle
//   out_valid - head entry valid
//   out_pc    - head pc, 0 when empty
//   out_instr - head instruction, NOP_INSTR when empty
//   count     - occupancy 0..DEPTH
module if_id_fifo
    import pipe_pkg::*;
#(
    parameter int              XLEN      = PIPE_XLEN,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(PIPE_NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occ;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head;

    assign in_ready  = (occ != (PTR_W+1)'(DEPTH));
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & ~stall & ~flush;
    assign count     = occ;

    fifo_regfile #(
        .DEPTH  (DEPTH),
        .WIDTH  (2*XLEN),
        .ADDR_W (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Gate by occupancy so unwritten storage never reaches ID.
    assign out_pc    = out_valid ? head[2*XLEN-1:XLEN] : '0;
    assign out_instr = out_valid ? head[XLEN-1:0]      : NOP_INSTR;

endmodule

// File: tb/tb_if_id_fifo.sv
// tb/tb_if_id_fifo.sv - self-checking bench for if_id_fifo
module tb_if_id_fifo;
    import pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_instr;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_instr;
    logic [2:0]       count;

    int vectors = 0;
    int miscompares = 0;
    bit model_ok = 1'b0;
    if_id_entry_t q[$];

    always #5 clk = ~clk;

    if_id_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .in_ready(in_ready), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    typedef struct {
        bit        rst;
        bit        vld;
        bit [31:0] pc;
        bit [31:0] ins;
        bit        stall;
        bit        flush;
        int        e_cnt;
        bit        e_vld;
        bit [31:0] e_pc;
        bit [31:0] e_ins;
        bit        e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of entries; outputs follow from its size and head.
    task automatic model_check();
        if (model_ok) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("m_pc", out_pc, (q.size() != 0) ? q[0].pc : 32'h0);
            chk("m_instr", out_instr, (q.size() != 0) ? q[0].instr : NOP);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [31:0] pc,
                         input logic [31:0] ins, input bit st, input bit fl);
        bit do_push, do_pop;
        if_id_entry_t e;
        model_check();
        rst = r; in_valid = v; in_pc = pc; in_instr = ins; stall = st; flush = fl;
        do_push = v && (q.size() < DEPTH) && !fl;
        do_pop  = (q.size() != 0) && !st && !fl;
        if (r || fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = ins;
                q.push_back(e);
            end
        end
        if (r) model_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit st, input bit fl, input int ec, input bit ev,
                       input logic [31:0] ep, input logic [31:0] ei, input bit er);
        vec_t t;
        t.rst = r; t.vld = v; t.pc = pc; t.ins = ins; t.stall = st; t.flush = fl;
        t.e_cnt = ec; t.e_vld = ev; t.e_pc = ep; t.e_ins = ei; t.e_rdy = er;
        tbl.push_back(t);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; stall = 1'b0; flush = 1'b0;
        #1;

        // reset then idle
        add(1,0,32'h00,32'h0,0,0, 0,0,32'h00,NOP,1);
        add(1,0,32'h00,32'h0,0,0, 0,0,32'h00,NOP,1);
        add(0,0,32'h00,32'h0,0,0, 0,0,32'h00,NOP,1);
        // fill under stall, fifth offer refused
        add(0,1,32'h00,32'hA0,1,0, 1,1,32'h00,32'hA0,1);
        add(0,1,32'h04,32'hA1,1,0, 2,1,32'h00,32'hA0,1);
        add(0,1,32'h08,32'hA2,1,0, 3,1,32'h00,32'hA0,1);
        add(0,1,32'h0C,32'hA3,1,0, 4,1,32'h00,32'hA0,0);
        add(0,1,32'h10,32'hA4,1,0, 4,1,32'h00,32'hA0,0);
        // drain across the pointer wrap; full-cycle pop does not admit the offer
        add(0,1,32'h10,32'hA4,0,0, 3,1,32'h04,32'hA1,1);
        add(0,1,32'h10,32'hA4,0,0, 3,1,32'h08,32'hA2,1);
        add(0,1,32'h14,32'hA5,0,0, 3,1,32'h0C,32'hA3,1);
        add(0,0,32'h00,32'h0,0,0, 2,1,32'h10,32'hA4,1);
        // push and pop together at count 2
        add(0,1,32'h20,32'hB0,0,0, 2,1,32'h14,32'hA5,1);
        add(0,0,32'h00,32'h0,0,0, 1,1,32'h20,32'hB0,1);
        // build count 3, then flush under stall with an offer
        add(0,1,32'h24,32'hB1,1,0, 2,1,32'h20,32'hB0,1);
        add(0,1,32'h28,32'hB2,1,0, 3,1,32'h20,32'hB0,1);
        add(0,1,32'h2C,32'hB3,1,1, 0,0,32'h00,NOP,1);
        add(0,1,32'h40,32'hC0,0,0, 1,1,32'h40,32'hC0,1);
        add(0,0,32'h00,32'h0,0,0, 0,0,32'h00,NOP,1);
        // reset mid-operation with a push in flight
        add(0,1,32'h50,32'hD0,1,0, 1,1,32'h50,32'hD0,1);
        add(0,1,32'h54,32'hD1,1,0, 2,1,32'h50,32'hD0,1);
        add(0,1,32'h58,32'hD2,1,0, 3,1,32'h50,32'hD0,1);
        add(0,1,32'h5C,32'hD3,1,0, 0,0,32'h00,NOP,1);
        add(0,0,32'h00,32'h0,0,0, 0,0,32'h00,NOP,1);
        tbl[22].rst = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].pc, tbl[i].ins, tbl[i].stall, tbl[i].flush);
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
            chk($sformatf("t%0d_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("t%0d_instr", i), out_instr, tbl[i].e_ins);
            chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
        end

        // simultaneous flush and reset
        cycle(0,1,32'h60,32'hE0,1,0);
        cycle(1,1,32'h64,32'hE1,0,1);
        chk("rstflush_count", 32'(count), 32'h0);

        // randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0,63) == 0, $urandom_range(0,1) == 1, $urandom, $urandom,
                  $urandom_range(0,2) == 0, $urandom_range(0,15) == 0);
        end
        model_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
